shift_arbiter: RTL and testbench

Shares the single 16-bit barrel shifter between two requesters, e.g. the EX-stage ALU path and the address/immediate-formation unit. Round-robin arbitration is used, with one operation in flight at a time. Operands are latched and the result is registered. Each requester has its own valid/ready request channel and its own response channel, so the shifter's combinational path is cut from both requesters.

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_arbiter_if.sv | 47 ++++
 rtl/shift_arbiter_shifter.sv | 33 +++
 rtl/shift_arbiter.sv | 113 +++++++++++
 tb/tb_shift_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Brief    : Shared widths, shift-mode codes and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRA = 2'b01;
  localparam logic [1:0] SHIFT_ROR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } shift_state_t;

endpackage
`default_nettype wire

// File: rtl/shift_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter_if
// Brief    : Two request channels and two response channels of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_arbiter_if;
  import shift_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [AMT_W-1:0]  req0_amt;
  logic [1:0]        req0_mode;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [AMT_W-1:0]  req1_amt;
  logic [1:0]        req1_mode;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_data;

  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_data;

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_mode,
    input  req1_valid, req1_data, req1_amt, req1_mode,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

  modport master (
    output req0_valid, req0_data, req0_amt, req0_mode,
    output req1_valid, req1_data, req1_amt, req1_mode,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

endinterface
`default_nettype wire

// File: rtl/shift_arbiter_shifter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter_shifter
// Brief    : Combinational 16-bit barrel shifter (SLL / SRA / ROR).
// Revision : 1.0 - initial release
// ============================================================================
module shift_arbiter_shifter
  import shift_pkg::*;
(
  input  wire logic [DATA_W-1:0] i_data,
  input  wire logic [AMT_W-1:0]  i_amt,
  input  wire logic [1:0]        i_mode,
  output logic      [DATA_W-1:0] o_result
);

  localparam logic [AMT_W:0] c_width = (AMT_W + 1)'(DATA_W);

  logic [DATA_W-1:0] w_ror;

  // amt=0 gives a left shift by the full width, which clears to zero.
  assign w_ror = (i_data >> i_amt) | (i_data << (c_width - {1'b0, i_amt}));

  always_comb begin
    o_result = w_ror;
    case (i_mode)
      SHIFT_SLL: o_result = i_data << i_amt;
      SHIFT_SRA: o_result = $signed(i_data) >>> i_amt;
      default:   o_result = w_ror;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter
// Brief    : Round-robin sharing of one barrel shifter between two requesters.
//            Define SHIFT_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
// Revision : 1.0 - initial release
// ============================================================================
module shift_arbiter
  import shift_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  shift_arbiter_if.slave     bus
);

  shift_state_t      r_state;
  shift_state_t      w_state_nxt;
  logic              r_rr_last;
  logic              r_id;
  logic [DATA_W-1:0] r_data;
  logic [AMT_W-1:0]  r_amt;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_result;

  logic              w_grant_any;
  logic              w_grant_id;
  logic              w_accept;
  logic              w_rsp_ready;
  logic [DATA_W-1:0] w_shift;

  assign w_grant_any = bus.req0_valid | bus.req1_valid;
  assign w_accept    = (r_state == IDLE) && w_grant_any;
  assign w_rsp_ready = r_id ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    w_grant_id = ~bus.req0_valid;
`else
    // On a tie the requester that was not served last wins.
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant_id = ~r_rr_last;
    end else begin
      w_grant_id = bus.req1_valid;
    end
`endif
  end

  shift_arbiter_shifter u_shifter (
    .i_data   (r_data),
    .i_amt    (r_amt),
    .i_mode   (r_mode),
    .o_result (w_shift)
  );

  always_comb begin
    w_state_nxt    = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_any) begin
          bus.req0_ready = ~w_grant_id;
          bus.req1_ready = w_grant_id;
          w_state_nxt    = EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        bus.rsp0_valid = ~r_id;
        bus.rsp1_valid = r_id;
        if (w_rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.rsp0_data = r_result;
  assign bus.rsp1_data = r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b1;
      r_id      <= 1'b0;
      r_data    <= '0;
      r_amt     <= '0;
      r_mode    <= SHIFT_SLL;
      r_result  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_id      <= w_grant_id;
        r_rr_last <= w_grant_id;
        r_data    <= w_grant_id ? bus.req1_data : bus.req0_data;
        r_amt     <= w_grant_id ? bus.req1_amt  : bus.req0_amt;
        r_mode    <= w_grant_id ? bus.req1_mode : bus.req0_mode;
      end
      if (r_state == EXEC) begin
        r_result <= w_shift;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arbiter
// Brief    : Directed scoreboard bench for shift_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;
  import shift_pkg::*;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc [2];
  exp_t exp_q [$];
  logic prev_v0 = 1'b0;
  logic prev_v1 = 1'b0;

  shift_arbiter_if bus ();

  shift_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic pop_check(input logic id, input logic [15:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_rsp: got rsp%0d data 0x%0h, want no response", id, data);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_id", 32'(id), 32'(e.id));
      chk("rsp_data", 32'(data), 32'(e.data));
    end
  endtask

  // Monitor: compares every response handshake against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_v0 <= 1'b0;
      prev_v1 <= 1'b0;
    end else begin
      if (bus.rsp0_valid || bus.rsp1_valid)
        chk("one_rsp_valid", 32'(bus.rsp0_valid & bus.rsp1_valid), 32'd0);
      if (bus.rsp0_valid && !prev_v0) chk("latency0", 32'(cyc - acc_cyc[0]), 32'd2);
      if (bus.rsp1_valid && !prev_v1) chk("latency1", 32'(cyc - acc_cyc[1]), 32'd2);
      if (bus.rsp0_valid && bus.rsp0_ready) pop_check(1'b0, bus.rsp0_data);
      if (bus.rsp1_valid && bus.rsp1_ready) pop_check(1'b1, bus.rsp1_data);
      prev_v0 <= bus.rsp0_valid;
      prev_v1 <= bus.rsp1_valid;
    end
  end

  task automatic set_req(input int id, input logic [15:0] d, input logic [3:0] a,
                         input logic [1:0] m);
    if (id == 0) begin
      bus.req0_data = d; bus.req0_amt = a; bus.req0_mode = m; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_data = d; bus.req1_amt = a; bus.req1_mode = m; bus.req1_valid = 1'b1;
    end
  endtask

  task automatic expect_rsp(input int id, input logic [15:0] d);
    exp_t e;
    e.id   = (id != 0);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_accept(input int id);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (id == 0 ? (bus.req0_valid && bus.req0_ready) : (bus.req1_valid && bus.req1_ready)) begin
        acc_cyc[id] = cyc;
        tests++;
        @(posedge clk);
        #1;
        if (id == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL accept%0d: got no ready in 50 cycles, want ready=1", id);
    if (id == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] modes [3];
    modes = '{SHIFT_SLL, SHIFT_SRA, SHIFT_ROR};
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_amt = '0; bus.req0_mode = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_amt = '0; bus.req1_mode = '0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    chk("rst_rsp0_data", 32'(bus.rsp0_data), 32'h0);
    chk("rst_rsp1_data", 32'(bus.rsp1_data), 32'h0);
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    @(posedge clk);
    #1;

    // Single requests in each mode
    set_req(0, 16'h8001, 4'd1, SHIFT_SLL); expect_rsp(0, 16'h0002); wait_accept(0); drain();
    set_req(1, 16'h8000, 4'd4, SHIFT_SRA); expect_rsp(1, 16'hF800); wait_accept(1); drain();
    set_req(1, 16'h1234, 4'd8, 2'b11);     expect_rsp(1, 16'h3412); wait_accept(1); drain();

    // Tie after rr_last=1: requester 0 first
    set_req(0, 16'h0001, 4'd15, SHIFT_SLL);
    set_req(1, 16'h00F0, 4'd4, SHIFT_ROR);
    expect_rsp(0, 16'h8000);
    expect_rsp(1, 16'h000F);
    fork
      wait_accept(0);
      wait_accept(1);
    join
    drain();

    // Serve requester 0 alone, so the next tie goes to requester 1
    set_req(0, 16'h7000, 4'd12, SHIFT_SRA); expect_rsp(0, 16'h0007); wait_accept(0); drain();
    set_req(0, 16'hF00F, 4'd4, SHIFT_ROR);
    set_req(1, 16'h0F00, 4'd4, SHIFT_SLL);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    expect_rsp(0, 16'hFF00);
    expect_rsp(1, 16'hF000);
`else
    expect_rsp(1, 16'hF000);
    expect_rsp(0, 16'hFF00);
`endif
    fork
      wait_accept(0);
      wait_accept(1);
    join
    drain();

    // Response back-pressure with requester 1 pending
    bus.rsp0_ready = 1'b0;
    set_req(0, 16'h0001, 4'd1, SHIFT_ROR); expect_rsp(0, 16'h8000); wait_accept(0);
    set_req(1, 16'h0003, 4'd2, SHIFT_SLL); expect_rsp(1, 16'h000C);
    for (int i = 0; i < 10 && !bus.rsp0_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
      chk("hold_rsp0_data", 32'(bus.rsp0_data), 32'h8000);
      chk("hold_req0_ready", 32'(bus.req0_ready), 32'd0);
      chk("hold_req1_ready", 32'(bus.req1_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.rsp0_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_rsp", 32'(bus.req1_ready), 32'd1);
    if (bus.req1_ready) begin
      acc_cyc[1] = cyc;
      @(posedge clk);
      #1 bus.req1_valid = 1'b0;
    end else begin
      wait_accept(1);
    end
    drain();

    // Reset while the operation is in EXEC drops it
    set_req(0, 16'h1111, 4'd1, SHIFT_SLL);
    wait_accept(0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drop_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      chk("drop_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      chk("drop_rsp0_data", 32'(bus.rsp0_data), 32'h0);
      chk("drop_rsp1_data", 32'(bus.rsp1_data), 32'h0);
    end
    @(posedge clk);
    #1;
    set_req(1, 16'h00F0, 4'd4, SHIFT_ROR); expect_rsp(1, 16'h000F); wait_accept(1); drain();

    // amt=0 is identity in every mode
    for (int m = 0; m < 3; m++) begin
      set_req(0, 16'hA5C3, 4'd0, modes[m]);
      expect_rsp(0, 16'hA5C3);
      wait_accept(0);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
